chroma_subsample_420: RTL and testbench

Converts a full-rate 4:4:4 YUV pixel stream from the colour-space converter into the 4:2:0 component stream consumed by the JPEG MCU buffer. Luma passes through one sample per pixel. Chroma is reduced 2×2 by averaging, using a half-width line buffer. Each chroma pair is emitted as two beats, U then V, both tagged with the same pixel/line count so the MCU buffer addresses them identically. The block sits directly upstream of the MCU buffer in the camera `clk` domain.

---
 rtl/chroma_subsample_420.sv | 204 ++++++++++++++++++++
 tb/tb_chroma_subsample_420.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chroma_subsample_420.sv
// chroma_subsample_420
//
// Converts a 4:4:4 YUV pixel stream into the 4:2:0 component stream used by
// the JPEG MCU buffer. Luma passes through one beat per pixel. Chroma is
// reduced once per 2x2 block and leaves as two beats sharing the tags of the
// odd-line, odd-pixel position:
//   beat A: valid 3'b010, U
//   beat B: valid 3'b101, Y + V (carries eof)
// Y rides with V so that the MCU buffer's end-of-line push (Y valid at
// x_size_m1) comes after the last chroma write of that line.
//
// Lane mapping: index 0 = Y, 1 = U, 2 = V (for data and valid alike).
//
// Optional feature macro: CHROMA_SUBSAMPLE_AVG_EN
//   defined   : 2x2 rounded average through a half-width line buffer
//   undefined : decimation, U/V taken from the odd-line, even-pixel sample
//
// Ports
//   clk, resetn               pixel clock, asynchronous active-low reset
//   yuv_in, yuv_in_valid      input pixel (Y,U,V) and its valid
//   yuv_in_hold               upstream must hold the current pixel
//   yuv_in_pixel_count/line   x / y position of the input pixel
//   eof_in                    last pixel of the frame
//   x_size_m1                 line width - 1 (odd); wider pixels are dropped
//   yuvrgb_out(_valid)        output beat and per-lane valid
//   yuvrgb_out_hold           downstream stall
//   yuvrgb_out_pixel/line     tags of the current beat
//   eof_out                   final beat of the frame
//   fsm_state_o               debug view of the beat sequencer (1 = V pending)
//
// Handshake: an input pixel transfers on a clock edge where
// yuv_in_valid=1 and yuv_in_hold=0. An output beat transfers on an edge where
// yuvrgb_out_valid!=0 and yuvrgb_out_hold=0; while it is stalled every output
// field stays stable.
module chroma_subsample_420 #(
    parameter int SENSOR_X_SIZE = 720,
    parameter int SENSOR_Y_SIZE = 720,
    parameter int DW            = 8,
    localparam int XW           = $clog2(SENSOR_X_SIZE),
    localparam int YW           = $clog2(SENSOR_Y_SIZE)
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [2:0][DW-1:0] yuv_in,
    input  logic               yuv_in_valid,
    output logic               yuv_in_hold,
    input  logic [XW-1:0]      yuv_in_pixel_count,
    input  logic [YW-1:0]      yuv_in_line_count,
    input  logic               eof_in,
    input  logic [XW-1:0]      x_size_m1,
    output logic [2:0][DW-1:0] yuvrgb_out,
    output logic [2:0]         yuvrgb_out_valid,
    input  logic               yuvrgb_out_hold,
    output logic [XW-1:0]      yuvrgb_out_pixel_count,
    output logic [YW-1:0]      yuvrgb_out_line_count,
    output logic               eof_out,
    output logic               fsm_state_o
);

    typedef enum logic {
        PASS   = 1'b0,
        V_PEND = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic               out_busy;
    logic               accept;
    logic               in_range;
    logic               take;
    logic               ly;
    logic               px;

    logic [DW-1:0]      u0_q, v0_q;
    logic [DW-1:0]      y_pend_q, v_pend_q;
    logic               eof_pend_q;
    logic [DW-1:0]      u_res, v_res;

    logic [2:0]         valid_q;
    logic [2:0][DW-1:0] data_q;
    logic [XW-1:0]      pix_q;
    logic [YW-1:0]      line_q;
    logic               eof_q;

    assign out_busy    = (|valid_q) & yuvrgb_out_hold;
    assign yuv_in_hold = out_busy | (state_q == V_PEND);
    assign accept      = yuv_in_valid & ~yuv_in_hold;
    // Pixels beyond the programmed width are consumed but produce nothing.
    assign in_range    = (yuv_in_pixel_count <= x_size_m1);
    assign take        = accept & in_range;
    assign ly          = yuv_in_line_count[0];
    assign px          = yuv_in_pixel_count[0];

`ifdef CHROMA_SUBSAMPLE_AVG_EN
    localparam int SW       = DW + 1;
    localparam int LB_DEPTH = SENSOR_X_SIZE / 2;

    // Horizontal pair sums of the even line: {V sum, U sum}.
    logic [2*SW-1:0] lbuf [LB_DEPTH];
    logic [2*SW-1:0] lb_rdata;
    logic [XW-2:0]   lb_addr;
    logic [SW-1:0]   sum_u, sum_v;
    logic [DW+1:0]   avg_u_full, avg_v_full;

    assign lb_addr = yuv_in_pixel_count[XW-1:1];
    assign sum_u   = {1'b0, u0_q} + {1'b0, yuv_in[1]};
    assign sum_v   = {1'b0, v0_q} + {1'b0, yuv_in[2]};

    // Read is issued on the odd line's even pixel; the read register only
    // changes on a read, so the sum survives any stall before the odd pixel.
    always_ff @(posedge clk) begin
        if (take & ~ly & px) begin
            lbuf[lb_addr] <= {sum_v, sum_u};
        end
        if (take & ly & ~px) begin
            lb_rdata <= lbuf[lb_addr];
        end
    end

    // Four samples plus 2 for round-half-up; the quotient always fits DW.
    assign avg_u_full = {1'b0, lb_rdata[SW-1:0]} + {2'b00, u0_q}
                      + {2'b00, yuv_in[1]} + (DW+2)'(2);
    assign avg_v_full = {1'b0, lb_rdata[2*SW-1:SW]} + {2'b00, v0_q}
                      + {2'b00, yuv_in[2]} + (DW+2)'(2);
    assign u_res      = avg_u_full[DW+1:2];
    assign v_res      = avg_v_full[DW+1:2];
`else
    // Decimation: the odd-line even-pixel sample stands for the whole block.
    assign u_res = u0_q;
    assign v_res = v0_q;
`endif

    // Beat sequencer
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= PASS;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            PASS:    if (take & ly & px) state_d = V_PEND;
            V_PEND:  if (!out_busy)      state_d = PASS;
            default: state_d = PASS;
        endcase
    end

    // Input latches and output register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            u0_q       <= '0;
            v0_q       <= '0;
            y_pend_q   <= '0;
            v_pend_q   <= '0;
            eof_pend_q <= 1'b0;
            valid_q    <= '0;
            data_q     <= '0;
            pix_q      <= '0;
            line_q     <= '0;
            eof_q      <= 1'b0;
        end else begin
            if (take & ~px) begin
                u0_q <= yuv_in[1];
                v0_q <= yuv_in[2];
            end
            if (!out_busy) begin
                valid_q <= '0;
                eof_q   <= 1'b0;
                if (state_q == V_PEND) begin
                    // Beat B reuses beat A's tags, still held in pix_q/line_q.
                    valid_q   <= 3'b101;
                    data_q[0] <= y_pend_q;
                    data_q[2] <= v_pend_q;
                    eof_q     <= eof_pend_q;
                end else if (take) begin
                    pix_q  <= yuv_in_pixel_count;
                    line_q <= yuv_in_line_count;
                    if (ly & px) begin
                        valid_q    <= 3'b010;
                        data_q[1]  <= u_res;
                        y_pend_q   <= yuv_in[0];
                        v_pend_q   <= v_res;
                        eof_pend_q <= eof_in;
                    end else begin
                        valid_q   <= 3'b001;
                        data_q[0] <= yuv_in[0];
                        eof_q     <= eof_in;
                    end
                end
            end
        end
    end

    assign yuvrgb_out             = data_q;
    assign yuvrgb_out_valid       = valid_q;
    assign yuvrgb_out_pixel_count = pix_q;
    assign yuvrgb_out_line_count  = line_q;
    assign eof_out                = eof_q;
    assign fsm_state_o            = state_q;

endmodule

// File: tb/tb_chroma_subsample_420.sv
module tb_chroma_subsample_420;

    localparam int DW = 8;
    localparam int XW = 10;
    localparam int YW = 10;

    typedef struct packed {
        logic [2:0]    vld;
        logic [DW-1:0] y;
        logic [DW-1:0] u;
        logic [DW-1:0] v;
        logic [XW-1:0] px;
        logic [YW-1:0] ln;
        logic          eof;
    } beat_t;

    localparam int EW = $bits(beat_t);

    // 4x2 frame vectors: index = line*4 + pixel; expected chroma per block.
    typedef struct packed {
        logic [7:0][DW-1:0] u;
        logic [7:0][DW-1:0] v;
        logic [1:0][DW-1:0] eu_avg;
        logic [1:0][DW-1:0] ev_avg;
        logic [1:0][DW-1:0] eu_dec;
        logic [1:0][DW-1:0] ev_dec;
    } tv_t;

    // ---------------- clock / reset / DUT ----------------
    logic               clk = 1'b0;
    logic               resetn = 1'b0;
    logic [2:0][DW-1:0] yuv_in = '0;
    logic               yuv_in_valid = 1'b0;
    logic               yuv_in_hold;
    logic [XW-1:0]      yuv_in_pixel_count = '0;
    logic [YW-1:0]      yuv_in_line_count = '0;
    logic               eof_in = 1'b0;
    logic [XW-1:0]      x_size_m1 = 10'd3;
    logic [2:0][DW-1:0] yuvrgb_out;
    logic [2:0]         yuvrgb_out_valid;
    logic               yuvrgb_out_hold = 1'b0;
    logic [XW-1:0]      yuvrgb_out_pixel_count;
    logic [YW-1:0]      yuvrgb_out_line_count;
    logic               eof_out;
    logic               fsm_state_o;

    always #5 clk = ~clk;

    chroma_subsample_420 dut (
        .clk                    (clk),
        .resetn                 (resetn),
        .yuv_in                 (yuv_in),
        .yuv_in_valid           (yuv_in_valid),
        .yuv_in_hold            (yuv_in_hold),
        .yuv_in_pixel_count     (yuv_in_pixel_count),
        .yuv_in_line_count      (yuv_in_line_count),
        .eof_in                 (eof_in),
        .x_size_m1              (x_size_m1),
        .yuvrgb_out             (yuvrgb_out),
        .yuvrgb_out_valid       (yuvrgb_out_valid),
        .yuvrgb_out_hold        (yuvrgb_out_hold),
        .yuvrgb_out_pixel_count (yuvrgb_out_pixel_count),
        .yuvrgb_out_line_count  (yuvrgb_out_line_count),
        .eof_out                (eof_out),
        .fsm_state_o            (fsm_state_o)
    );

    // ---------------- bookkeeping ----------------
    int checks   = 0;
    int failures = 0;
    logic [EW-1:0] exp_q[$];
    bit  sb_en   = 1'b1;
    bit  bp_mode = 1'b0;
    int  n_ubeat = 0;
    int  n_eof   = 0;
    logic [XW-1:0] eof_px = '0;
    logic [YW-1:0] eof_ln = '0;

    beat_t cur;
    assign cur = '{vld: yuvrgb_out_valid, y: yuvrgb_out[0], u: yuvrgb_out[1],
                   v: yuvrgb_out[2], px: yuvrgb_out_pixel_count,
                   ln: yuvrgb_out_line_count, eof: eof_out};

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] expv);
        checks++;
        if (got !== expv) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, got, expv);
        end
    endtask

    // Random downstream stall
    always @(posedge clk) begin
        #1;
        if (bp_mode) yuvrgb_out_hold = ($urandom_range(0, 3) == 0);
    end

    // ---------------- scoreboard monitor ----------------
    function automatic beat_t mask_lanes(input beat_t g, input beat_t e);
        beat_t r = g;
        if (!e.vld[0]) r.y = e.y;
        if (!e.vld[1]) r.u = e.u;
        if (!e.vld[2]) r.v = e.v;
        return r;
    endfunction

    bit    held_prev = 1'b0;
    beat_t held_snap;

    always @(negedge clk) begin
        if (resetn && sb_en) begin
            if (held_prev) begin
                checks++;
                if (cur !== held_snap) begin
                    failures++;
                    $display("FAIL hold_stable got=%h expected=%h", cur, held_snap);
                end
            end
            held_prev = 1'b0;
            if (cur.vld != 3'b000) begin
                if (yuvrgb_out_hold) begin
                    held_prev = 1'b1;
                    held_snap = cur;
                end else begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_beat got=%h expected=none", cur);
                    end else begin
                        beat_t e;
                        beat_t g;
                        e = beat_t'(exp_q.pop_front());
                        g = mask_lanes(cur, e);
                        if (g !== e) begin
                            failures++;
                            $display("FAIL beat got=vld%b y%0d u%0d v%0d x%0d y%0d eof%0b expected=vld%b y%0d u%0d v%0d x%0d y%0d eof%0b",
                                     g.vld, g.y, g.u, g.v, g.px, g.ln, g.eof,
                                     e.vld, e.y, e.u, e.v, e.px, e.ln, e.eof);
                        end
                    end
                    if (cur.vld == 3'b010) n_ubeat++;
                    if (cur.eof) begin
                        n_eof++;
                        eof_px = cur.px;
                        eof_ln = cur.ln;
                    end
                end
            end
        end else begin
            held_prev = 1'b0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive_px(input logic [DW-1:0] y, input logic [DW-1:0] u,
                            input logic [DW-1:0] v, input int px, input int ln,
                            input logic eof, input logic [DW-1:0] eu,
                            input logic [DW-1:0] ev, input bit push);
        bit ok = 1'b0;
        yuv_in             = {v, u, y};
        yuv_in_pixel_count = XW'(px);
        yuv_in_line_count  = YW'(ln);
        eof_in             = eof;
        yuv_in_valid       = 1'b1;
        for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge clk);
            if (!yuv_in_hold) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        yuv_in_valid = 1'b0;
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout got=held expected=accepted x=%0d y=%0d", px, ln);
        end else if (push) begin
            if ((ln % 2 == 1) && (px % 2 == 1)) begin
                exp_q.push_back(beat_t'{vld: 3'b010, y: '0, u: eu, v: '0,
                                        px: XW'(px), ln: YW'(ln), eof: 1'b0});
                exp_q.push_back(beat_t'{vld: 3'b101, y: y, u: '0, v: ev,
                                        px: XW'(px), ln: YW'(ln), eof: eof});
            end else begin
                exp_q.push_back(beat_t'{vld: 3'b001, y: y, u: '0, v: '0,
                                        px: XW'(px), ln: YW'(ln), eof: eof});
            end
        end
    endtask

    task automatic wait_drain();
        for (int t = 0; t < 2000 && exp_q.size() != 0; t++) @(negedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout got=%0d expected=0 pending beats", exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    tv_t tv[4];

    task automatic drive_frame(input int t);
        for (int ln = 0; ln < 2; ln++) begin
            for (int px = 0; px < 4; px++) begin
                logic [DW-1:0] eu, ev;
`ifdef CHROMA_SUBSAMPLE_AVG_EN
                eu = tv[t].eu_avg[px/2];
                ev = tv[t].ev_avg[px/2];
`else
                eu = tv[t].eu_dec[px/2];
                ev = tv[t].ev_dec[px/2];
`endif
                drive_px(DW'(t*16 + ln*4 + px + 1), tv[t].u[ln*4+px], tv[t].v[ln*4+px],
                         px, ln, (ln == 1 && px == 3), eu, ev, 1'b1);
            end
        end
    endtask

    // ---------------- test sequence ----------------
    logic [DW-1:0] bu[720];
    logic [DW-1:0] bv[720];

    initial begin
        // Rounding frame
        tv[0].u      = {8'd41, 8'd31, 8'd21, 8'd11, 8'd40, 8'd30, 8'd20, 8'd10};
        tv[0].v      = {8'd131, 8'd121, 8'd111, 8'd101, 8'd130, 8'd120, 8'd110, 8'd100};
        tv[0].eu_avg = {8'd36, 8'd16};
        tv[0].ev_avg = {8'd126, 8'd106};
        tv[0].eu_dec = {8'd31, 8'd11};
        tv[0].ev_dec = {8'd121, 8'd101};
        // All full scale
        tv[1].u      = '1;
        tv[1].v      = '1;
        tv[1].eu_avg = {8'd255, 8'd255};
        tv[1].ev_avg = {8'd255, 8'd255};
        tv[1].eu_dec = {8'd255, 8'd255};
        tv[1].ev_dec = {8'd255, 8'd255};
        // All zero
        tv[2]        = '0;
        // Rounding corners: U 1,0,0,0 -> 0 and 2,0,0,0 -> 1; V 3,0,0,0 -> 1 and 3,3,3,0 -> 2
        tv[3].u      = {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd2, 8'd0, 8'd1};
        tv[3].v      = {8'd0, 8'd3, 8'd0, 8'd0, 8'd3, 8'd3, 8'd0, 8'd3};
        tv[3].eu_avg = {8'd1, 8'd0};
        tv[3].ev_avg = {8'd2, 8'd1};
        tv[3].eu_dec = {8'd0, 8'd0};
        tv[3].ev_dec = {8'd3, 8'd0};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_valid", 64'(yuvrgb_out_valid), 64'd0);
        chk("reset_eof", 64'(eof_out), 64'd0);
        chk("reset_in_hold", 64'(yuv_in_hold), 64'd0);
        chk("reset_state", 64'(fsm_state_o), 64'd0);
        chk("reset_data", 64'(yuvrgb_out), 64'd0);
        chk("reset_tags", 64'({yuvrgb_out_pixel_count, yuvrgb_out_line_count}), 64'd0);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // Table-driven 4x2 frames; random stall on the later ones
        x_size_m1 = 10'd3;
        for (int t = 0; t < 4; t++) begin
            bp_mode = (t >= 2);
            drive_frame(t);
            wait_drain();
            bp_mode = 1'b0;
            yuvrgb_out_hold = 1'b0;
        end

        // Backpressure on beat A: 5 stalled cycles, B exactly one cycle after A goes
        fork
            drive_frame(0);
            begin
                bit found = 1'b0;
                for (int t = 0; t < 100 && !found; t++) begin
                    @(posedge clk);
                    #1;
                    if (yuvrgb_out_valid == 3'b010) found = 1'b1;
                end
                if (!found) begin
                    chk("bp_beat_a_seen", 64'd0, 64'd1);
                end else begin
                    yuvrgb_out_hold = 1'b1;
                    for (int k = 0; k < 5; k++) begin
                        @(negedge clk);
                        chk("bp_a_held_valid", 64'(yuvrgb_out_valid), 64'b010);
                        chk("bp_in_hold", 64'(yuv_in_hold), 64'd1);
                    end
                    @(posedge clk);
                    #1;
                    yuvrgb_out_hold = 1'b0;
                    @(negedge clk);
                    chk("bp_a_taken", 64'(yuvrgb_out_valid), 64'b010);
                    chk("bp_in_hold_at_take", 64'(yuv_in_hold), 64'd1);
                    @(negedge clk);
                    chk("bp_b_next_cycle", 64'(yuvrgb_out_valid), 64'b101);
                end
            end
        join
        wait_drain();

        // Reset while V is pending
        sb_en = 1'b0;
        drive_px(8'd7, 8'd50, 8'd60, 0, 1, 1'b0, '0, '0, 1'b0);
        drive_px(8'd8, 8'd52, 8'd62, 1, 1, 1'b0, '0, '0, 1'b0);
        yuvrgb_out_hold = 1'b1;
        @(negedge clk);
        chk("vpend_state", 64'(fsm_state_o), 64'd1);
        chk("vpend_beat_a", 64'(yuvrgb_out_valid), 64'b010);
        resetn = 1'b0;
        #1;
        chk("rst_valid_async", 64'(yuvrgb_out_valid), 64'd0);
        @(posedge clk);
        #1;
        chk("rst_valid_edge", 64'(yuvrgb_out_valid), 64'd0);
        chk("rst_in_hold", 64'(yuv_in_hold), 64'd0);
        chk("rst_state", 64'(fsm_state_o), 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        yuvrgb_out_hold = 1'b0;
        begin
            bit seen = 1'b0;
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                if (yuvrgb_out_valid != 3'b000) seen = 1'b1;
            end
            chk("rst_no_v_emitted", 64'(seen), 64'd0);
        end
        exp_q.delete();
        sb_en = 1'b1;
        @(posedge clk);
        #1;
        // Frame restarts at line 0 after reset
        drive_frame(1);
        wait_drain();

        // Full-width frame: final line pair of a 720x720 frame
        x_size_m1 = 10'd719;
        n_ubeat = 0;
        n_eof = 0;
        bp_mode = 1'b1;
        begin
            logic [DW-1:0] u0, v0;
            u0 = '0;
            v0 = '0;
            for (int ln = 718; ln < 720; ln++) begin
                for (int x = 0; x < 720; x++) begin
                    logic [DW-1:0] y, u, v, eu, ev;
                    y = DW'($urandom_range(0, 255));
                    u = DW'($urandom_range(0, 255));
                    v = DW'($urandom_range(0, 255));
                    eu = '0;
                    ev = '0;
                    if (ln == 718) begin
                        bu[x] = u;
                        bv[x] = v;
                    end else if (x % 2 == 0) begin
                        u0 = u;
                        v0 = v;
                    end else begin
`ifdef CHROMA_SUBSAMPLE_AVG_EN
                        eu = DW'((int'(bu[x-1]) + int'(bu[x]) + int'(u0) + int'(u) + 2) / 4);
                        ev = DW'((int'(bv[x-1]) + int'(bv[x]) + int'(v0) + int'(v) + 2) / 4);
`else
                        eu = u0;
                        ev = v0;
`endif
                    end
                    drive_px(y, u, v, x, ln, (ln == 719 && x == 719), eu, ev, 1'b1);
                end
            end
        end
        wait_drain();
        bp_mode = 1'b0;
        yuvrgb_out_hold = 1'b0;
        chk("u_beat_count", 64'(n_ubeat), 64'd360);
        chk("eof_count", 64'(n_eof), 64'd1);
        chk("eof_tags", 64'({eof_px, eof_ln}), 64'({10'd719, 10'd719}));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

endmodule
